setpoint_key_ctrl: RTL

//  Consumes the 1 ms square wave from the clock divider (CP, toggles every 1 ms) and two raw push-buttons.

---
 rtl/temp_ctrl_pkg.sv | 17 +
 rtl/key_debounce.sv | 38 +++
 rtl/setpoint_key_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the thermostat: setpoint limits/defaults used by the
// key controller, comparator and display, plus the key-handling FSM encoding.
package temp_ctrl_pkg;

  localparam int SP_W_DEF       = 8;
  localparam int SP_MIN_DEF     = 0;
  localparam int SP_MAX_DEF     = 99;
  localparam int SP_DEFAULT_DEF = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2,
    ST_LOCK  = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser followed by a millisecond debounce counter.
// pressed is the debounced, active-high view of the active-low raw key.
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic key_n,
  output logic pressed
);

  logic [1:0] key_sync;
  logic       level;
  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sync <= 2'b11;
      level    <= 1'b1;
      cnt      <= '0;
    end else begin
      key_sync <= {key_sync[0], key_n};
      if (key_sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == 8'(DEBOUNCE_MS)) begin
        level <= key_sync[1];
        cnt   <= '0;
      end else if (ms_tick && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/setpoint_key_ctrl.sv
// UP/DOWN key handler stepping the temperature setpoint within [SP_MIN, SP_MAX].
// Define KEY_AUTOREPEAT_EN to enable hold-to-repeat; otherwise one step per press.
module setpoint_key_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int SP_W            = SP_W_DEF,
  parameter int SP_MIN          = SP_MIN_DEF,
  parameter int SP_MAX          = SP_MAX_DEF,
  parameter int SP_DEFAULT      = SP_DEFAULT_DEF,
`ifdef KEY_AUTOREPEAT_EN
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
`endif
  parameter int DEBOUNCE_MS     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cp_1ms,
  input  logic            key_up_n,
  input  logic            key_dn_n,
  output logic [SP_W-1:0] setpoint,
  output logic            sp_changed,
  output logic            key_held
);

  logic [2:0]      cp_sync;
  logic            ms_tick;
  logic            up_p, dn_p;
  key_state_t      state_q, state_d;
  logic            dir_q, dir_d;
  logic            step, step_up;
  logic [SP_W-1:0] sp_d;
`ifdef KEY_AUTOREPEAT_EN
  logic [15:0]     timer_q, timer_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cp_sync <= '0;
    else      cp_sync <= {cp_sync[1:0], cp_1ms};
  end

  // Both divider edges count, so one tick per millisecond.
  assign ms_tick = cp_sync[2] ^ cp_sync[1];

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_up (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .key_n(key_up_n), .pressed(up_p)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_dn (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .key_n(key_dn_n), .pressed(dn_p)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    step    = 1'b0;
    step_up = dir_q;
`ifdef KEY_AUTOREPEAT_EN
    timer_d = timer_q;
`endif
    if (up_p && dn_p) begin
      state_d = ST_LOCK;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (up_p ^ dn_p) begin
            step    = 1'b1;
            step_up = up_p;
            dir_d   = up_p;
            state_d = ST_PRESS;
`ifdef KEY_AUTOREPEAT_EN
            timer_d = '0;
`endif
          end
        end
        ST_PRESS, ST_HOLD: begin
          // The key that started the press owns it until released.
          if (!(dir_q ? up_p : dn_p)) begin
            state_d = ST_IDLE;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (ms_tick) begin
            if (timer_q == 16'((state_q == ST_PRESS) ? REPEAT_DELAY_MS - 1
                                                      : REPEAT_RATE_MS - 1)) begin
              step    = 1'b1;
              timer_d = '0;
              state_d = ST_HOLD;
            end else begin
              timer_d = timer_q + 16'd1;
            end
          end
`endif
        end
        ST_LOCK: begin
          if (!up_p && !dn_p) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Compare before add/sub so the value never wraps past the limits.
  always_comb begin
    sp_d = setpoint;
    if (step) begin
      if (step_up) begin
        if (setpoint < SP_W'(SP_MAX)) sp_d = setpoint + 1'b1;
      end else begin
        if (setpoint > SP_W'(SP_MIN)) sp_d = setpoint - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      setpoint   <= SP_W'(SP_DEFAULT);
      sp_changed <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      setpoint   <= sp_d;
      sp_changed <= (sp_d != setpoint);
`ifdef KEY_AUTOREPEAT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign key_held = (state_q == ST_PRESS) || (state_q == ST_HOLD);

endmodule
